// File: rtl/si_frame_decoder_pkg.sv
// Shared constants for the simple-interface frame decoder: default field widths
// and the FSM state encodings.
package si_frame_decoder_pkg;

    localparam int __REG_ADDR_WIDTH = 8;
    localparam int __REG_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } si_state_t;

    function automatic int bytes_for(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/si_gap_timer.sv
// Inter-byte gap counter: counts idle cycles while a frame is open and flags
// the cycle in which the gap reaches LIMIT cycles.
module si_gap_timer #(
    parameter int LIMIT = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic rx_rdy,
    output logic at_limit
);

    localparam int CW = $clog2(LIMIT);
    localparam logic [CW-1:0] TC = CW'(LIMIT - 1);

    logic [CW-1:0] count;

    // count holds the idle cycles already elapsed, so the current idle cycle is the LIMIT-th
    assign at_limit = en && (count == TC);

    always_ff @(posedge clk) begin
        if (rst || !en || rx_rdy || at_limit) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/si_frame_decoder.sv
// Byte-stream to simple-interface frame decoder (address bytes then data bytes,
// LSB byte first). Optional inter-byte timeout under SI_DECODER_TIMEOUT_EN.
//
//   state   | meaning
//   ST_IDLE | no bytes held
//   ST_ADDR | collecting address bytes
//   ST_DATA | collecting data bytes
module si_frame_decoder
    import si_frame_decoder_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = __REG_ADDR_WIDTH,
    parameter int REG_DATA_WIDTH = __REG_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                rx_data,
    input  logic                      rx_rdy,
    output logic [REG_ADDR_WIDTH-1:0] si_addr,
    output logic [REG_DATA_WIDTH-1:0] si_data,
    output logic                      si_rdy,
    output logic                      frame_err,
    output logic                      busy
);

    localparam int ADDR_BYTES = bytes_for(REG_ADDR_WIDTH);
    localparam int DATA_BYTES = bytes_for(REG_DATA_WIDTH);
    localparam int MAX_BYTES  = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
    localparam int CNT_W      = $clog2(MAX_BYTES + 1);
    // the first address byte is taken in IDLE, so ADDR sees one byte fewer
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'((ADDR_BYTES >= 2) ? ADDR_BYTES - 2 : 0);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BYTES - 1);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("si_frame_decoder: TIMEOUT_CYCLES must be at least 2");
    end

    si_state_t                 state, state_next;
    logic [CNT_W-1:0]          cnt, cnt_next;
    logic [REG_ADDR_WIDTH-1:0] addr_asm, addr_next;
    logic [REG_DATA_WIDTH-1:0] data_asm, data_next;
    logic                      addr_wr, data_wr, done, gap_limit;
    int                        addr_idx, data_idx;

`ifdef SI_DECODER_TIMEOUT_EN
    si_gap_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk      (clk),
        .rst      (rst),
        .en       (state != ST_IDLE),
        .rx_rdy   (rx_rdy),
        .at_limit (gap_limit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= gap_limit && !rx_rdy;
        end
    end
`else
    assign gap_limit = 1'b0;
    assign frame_err = 1'b0;
`endif

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        addr_wr    = 1'b0;
        data_wr    = 1'b0;
        done       = 1'b0;
        addr_idx   = 0;
        data_idx   = int'(cnt);
        addr_next  = addr_asm;
        data_next  = data_asm;

        unique case (state)
            ST_IDLE: begin
                if (rx_rdy) begin
                    addr_wr    = 1'b1;
                    cnt_next   = '0;
                    state_next = (ADDR_BYTES == 1) ? ST_DATA : ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (rx_rdy) begin
                    addr_wr  = 1'b1;
                    addr_idx = int'(cnt) + 1;
                    if (cnt == ADDR_LAST) begin
                        state_next = ST_DATA;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end else if (gap_limit) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            end
            ST_DATA: begin
                if (rx_rdy) begin
                    data_wr = 1'b1;
                    if (cnt == DATA_LAST) begin
                        done       = 1'b1;
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end else if (gap_limit) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase

        // bits of the final byte above the field width simply have no slot
        for (int i = 0; i < REG_ADDR_WIDTH; i++) begin
            if (addr_wr && (i / 8) == addr_idx) addr_next[i] = rx_data[i % 8];
        end
        for (int i = 0; i < REG_DATA_WIDTH; i++) begin
            if (data_wr && (i / 8) == data_idx) data_next[i] = rx_data[i % 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            addr_asm <= '0;
            data_asm <= '0;
            si_addr  <= '0;
            si_data  <= '0;
            si_rdy   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            addr_asm <= addr_next;
            data_asm <= data_next;
            si_rdy   <= done;
            busy     <= (state_next != ST_IDLE);
            if (done) begin
                si_addr <= addr_next;
                si_data <= data_next;
            end
        end
    end

endmodule

// File: tb/tb_si_frame_decoder.sv
// Directed bench for si_frame_decoder; the timeout checks run only when
// SI_DECODER_TIMEOUT_EN is defined, the no-timeout checks otherwise.
module tb_si_frame_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_rdy = 1'b0;
    logic [7:0]  si_addr;
    logic [15:0] si_data;
    logic        si_rdy, frame_err, busy;

    int total = 0;
    int bad = 0;
    int rdy_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    si_frame_decoder #(
        .REG_ADDR_WIDTH (8),
        .REG_DATA_WIDTH (16),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_rdy    (rx_rdy),
        .si_addr   (si_addr),
        .si_data   (si_data),
        .si_rdy    (si_rdy),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (si_rdy === 1'b1) rdy_cnt++;
        if (frame_err === 1'b1) err_cnt++;
        if (si_rdy === 1'b1 && frame_err === 1'b1) both_cnt++;
    end

    // inputs set here are captured by the next rising edge; outputs seen here
    // reflect every edge before this falling edge
    task automatic tick(input logic v, input logic [7:0] b);
        @(negedge clk);
        rx_rdy  = v;
        rx_data = b;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset, with bytes offered during reset that must be ignored
        tick(1'b1, 8'hFF);
        tick(1'b1, 8'hEE);
        tick(1'b0, 8'h00);
        check("rst_addr", 32'(si_addr), 32'h0);
        check("rst_data", 32'(si_data), 32'h0);
        check("rst_rdy", 32'(si_rdy), 32'h0);
        check("rst_err", 32'(frame_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;

        // single frame
        tick(1'b1, 8'h05);
        tick(1'b1, 8'h34);
        check("f1_rdy_early", 32'(si_rdy), 32'h0);
        check("f1_busy", 32'(busy), 32'h1);
        tick(1'b1, 8'h12);
        check("f1_rdy_pre", 32'(si_rdy), 32'h0);
        tick(1'b0, 8'h00);
        check("f1_rdy", 32'(si_rdy), 32'h1);
        check("f1_addr", 32'(si_addr), 32'h05);
        check("f1_data", 32'(si_data), 32'h1234);
        check("f1_busy_end", 32'(busy), 32'h0);
        tick(1'b0, 8'h00);
        check("f1_rdy_off", 32'(si_rdy), 32'h0);
        check("f1_addr_hold", 32'(si_addr), 32'h05);

        // back-to-back frames
        tick(1'b1, 8'h01);
        tick(1'b1, 8'hAA);
        tick(1'b1, 8'h00);
        tick(1'b1, 8'h02);
        check("b1_rdy", 32'(si_rdy), 32'h1);
        check("b1_addr", 32'(si_addr), 32'h01);
        check("b1_data", 32'(si_data), 32'h00AA);
        tick(1'b1, 8'h55);
        check("b2_rdy_mid", 32'(si_rdy), 32'h0);
        check("b2_busy_mid", 32'(busy), 32'h1);
        check("b2_addr_hold", 32'(si_addr), 32'h01);
        tick(1'b1, 8'h00);
        check("b2_rdy_mid2", 32'(si_rdy), 32'h0);
        tick(1'b0, 8'h00);
        check("b2_rdy", 32'(si_rdy), 32'h1);
        check("b2_addr", 32'(si_addr), 32'h02);
        check("b2_data", 32'(si_data), 32'h0055);
        tick(1'b0, 8'h00);
        check("b2_rdy_off", 32'(si_rdy), 32'h0);

        // reset mid-frame discards the partial frame
        tick(1'b1, 8'h07);
        tick(1'b1, 8'h11);
        tick(1'b0, 8'h00);
        rst = 1'b1;
        tick(1'b0, 8'h00);
        rst = 1'b0;
        check("mr_busy", 32'(busy), 32'h0);
        check("mr_rdy", 32'(si_rdy), 32'h0);
        check("mr_addr", 32'(si_addr), 32'h0);
        check("mr_data", 32'(si_data), 32'h0);
        tick(1'b1, 8'h03);
        tick(1'b1, 8'hEF);
        tick(1'b1, 8'hBE);
        tick(1'b0, 8'h00);
        check("mr_rdy_new", 32'(si_rdy), 32'h1);
        check("mr_addr_new", 32'(si_addr), 32'h03);
        check("mr_data_new", 32'(si_data), 32'hBEEF);
        tick(1'b0, 8'h00);
        check("rdy_pulses_a", 32'(rdy_cnt), 32'd4);

`ifdef SI_DECODER_TIMEOUT_EN
        // ten idle cycles after one byte abort the frame
        tick(1'b1, 8'h09);
        repeat (10) tick(1'b0, 8'h00);
        check("to_busy_pre", 32'(busy), 32'h1);
        check("to_err_pre", 32'(frame_err), 32'h0);
        tick(1'b0, 8'h00);
        check("to_err", 32'(frame_err), 32'h1);
        check("to_busy", 32'(busy), 32'h0);
        check("to_rdy", 32'(si_rdy), 32'h0);
        tick(1'b1, 8'h04);
        check("to_err_off", 32'(frame_err), 32'h0);
        tick(1'b1, 8'h22);
        tick(1'b1, 8'h11);
        tick(1'b0, 8'h00);
        check("to_rdy_new", 32'(si_rdy), 32'h1);
        check("to_addr_new", 32'(si_addr), 32'h04);
        check("to_data_new", 32'(si_data), 32'h1122);

        // a byte in the limit cycle wins over the timeout
        tick(1'b1, 8'h33);
        repeat (9) tick(1'b0, 8'h00);
        tick(1'b1, 8'h44);
        tick(1'b1, 8'h55);
        check("lim_err", 32'(frame_err), 32'h0);
        check("lim_busy", 32'(busy), 32'h1);
        tick(1'b0, 8'h00);
        check("lim_rdy", 32'(si_rdy), 32'h1);
        check("lim_addr", 32'(si_addr), 32'h33);
        check("lim_data", 32'(si_data), 32'h5544);
        repeat (12) tick(1'b0, 8'h00);
        check("lim_err_cnt", 32'(err_cnt), 32'd1);
        check("rdy_pulses_b", 32'(rdy_cnt), 32'd6);
`else
        // without the timeout a partial frame waits indefinitely
        tick(1'b1, 8'h09);
        repeat (10000) tick(1'b0, 8'h00);
        check("nt_busy", 32'(busy), 32'h1);
        tick(1'b1, 8'h78);
        tick(1'b1, 8'h56);
        tick(1'b0, 8'h00);
        check("nt_rdy", 32'(si_rdy), 32'h1);
        check("nt_addr", 32'(si_addr), 32'h09);
        check("nt_data", 32'(si_data), 32'h5678);
        tick(1'b0, 8'h00);
        check("nt_err_cnt", 32'(err_cnt), 32'd0);
        check("rdy_pulses_b", 32'(rdy_cnt), 32'd5);
`endif
        check("rdy_err_overlap", 32'(both_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
